ring_slot_arbiter: RTL and testbench
====================================

// Module: ring_slot_arbiter
// PURPOSE
//   Downstream consumer of the one-hot ring counter. Uses the rotating one-hot
//   Count vector as a time-slot pointer and grants a shared resource to the
//   requester whose slot is active. Each grant is held until that requester
//   signals done, or until a hold timeout expires. Also counts requests that
//   lost their slot while the resource was busy, and flags a corrupted
//   (non-one-hot) slot vector.
// PARAMETERS
//   N         4   number of slots/requesters; must match ring counter N
//   HOLD_MAX  8   max cycles a grant may stay high (>=2)
//   CW        8   width of miss counter
// PORTS
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   slot      in   N      one-hot slot pointer (ring counter Count)
//   req       in   N      per-requester request, level
//   done      in   N      per-requester release, sampled only on granted bit
//   gnt       out  N      registered one-hot grant, 0 when idle
//   busy      out  1      1 while a grant is held (state BUSY)
//   timeout   out  1      1-cycle pulse when a grant is revoked by HOLD_MAX
//   miss_cnt  out  CW     saturating count of missed slot requests
//   slot_err  out  1      sticky: slot was not one-hot (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, any time, including mid-grant): gnt=0, busy=0, timeout=0,
//     miss_cnt=0, slot_err=0, hold_cnt=0, state=IDLE. Effect is immediate.
//   FSM states: IDLE, BUSY.
//   IDLE, on posedge:
//     - slot valid and (slot & req)!=0 -> gnt<=slot, hold_cnt<=0, state->BUSY.
//       gnt is visible the cycle after slot/req are sampled (1-cycle latency).
//     - slot valid and (slot & req)==0 -> remain IDLE, no change.
//     - slot invalid -> remain IDLE, no grant.
//   BUSY, on posedge (checks in priority order):
//     1. (gnt & done)!=0 -> gnt<=0, state->IDLE, no timeout.
//        done and hold expiry on the same edge: done wins.
//     2. hold_cnt==HOLD_MAX-1 -> gnt<=0, timeout<=1 for one cycle, ->IDLE.
//     3. else hold_cnt<=hold_cnt+1, gnt held.
//     done on non-granted bits is ignored. gnt is high for at most HOLD_MAX
//     cycles.
//   After a release there is at least one IDLE cycle before the next grant;
//     release and a new grant never occur on the same edge.
//   Miss count: on a BUSY edge where (slot & req & ~gnt)!=0,
//     miss_cnt<=miss_cnt+1. Saturates at 2^CW-1 and never wraps. IDLE edges
//     never count.
//   busy == (state==BUSY). gnt is always 0 or one-hot.
//   Slot wrap: slot rotates freely; this block only samples it.
// CONFIGURATION
//   RING_SLOT_CHECK_EN defined:
//     - slot is valid only if exactly one bit is set.
//     - An invalid slot on any edge sets slot_err=1, sticky until rst.
//     - An invalid slot blocks new grants in IDLE.
//     - An active grant is unaffected by an invalid slot.
//   RING_SLOT_CHECK_EN undefined:
//     - slot_err is tied 0 and slot is treated as always valid.
//     - If several bits of (slot & req) are set, the lowest index is granted.
//     - slot==0 produces no grant.
// TESTING
//   T1 N=4: rst high mid-grant (gnt=0010) -> all outputs 0 immediately, IDLE.
//   T2 slot=0001, req=0001 -> gnt=0001 next cycle, busy=1; done[0]=1 for one
//      edge -> gnt=0000, busy=0, timeout stays 0.
//   T3 grant 0100, done never asserted, HOLD_MAX=8 -> gnt high exactly 8
//      cycles, timeout=1 for 1 cycle as gnt drops; done+expiry same edge ->
//      timeout=0.
//   T4 grant 0001 held while slot walks 0010,0100,1000 with req=1110 -> miss_cnt=3;
//      CW=2 with 5 misses -> miss_cnt=3 (saturated).
//   T5 RING_SLOT_CHECK_EN: slot=0011, req=0011 -> no grant, slot_err=1, stays 1
//      after slot=0001 grants normally. Undefined: same stimulus -> gnt=0001,
//      slot_err=0.
//   T6 done pulse then immediately slot=0010, req=0010 -> one idle cycle,
//      then gnt=0010.

Source files
------------

// File: rtl/ring_slot_arbiter.sv
// Slot-pointer arbiter driven by a one-hot ring counter; grants hold until done or timeout.
// Optional RING_SLOT_CHECK_EN: reject and flag non-one-hot slot vectors.
module ring_slot_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  slot,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic          timeout,
    output logic [CW-1:0] miss_cnt,
    output logic          slot_err
);

    localparam int HW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] MISS_MAX = '1;
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          slot_ok;
    logic [N-1:0]  cand;
    logic [N-1:0]  pick;
    logic          released;
    logic          missed;

`ifdef RING_SLOT_CHECK_EN
    assign slot_ok = (slot != '0) && ((slot & (slot - ONE)) == '0);
`else
    assign slot_ok = 1'b1;
`endif

    // Lowest set bit wins when more than one slot bit matches a request.
    always_comb begin
        cand = slot & req;
        pick = cand & (~cand + ONE);
    end

    assign released = (gnt & done) != '0;
    assign missed   = (slot & req & ~gnt) != '0;
    assign busy     = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (slot_ok && cand != '0) begin
                        gnt      <= pick;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (released) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        gnt     <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
        end else if (state == BUSY && missed && miss_cnt != MISS_MAX) begin
            miss_cnt <= miss_cnt + CW'(1);
        end
    end

`ifdef RING_SLOT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_err <= 1'b0;
        end else if (!slot_ok) begin
            slot_err <= 1'b1;
        end
    end
`else
    assign slot_err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// Directed bench for ring_slot_arbiter; a second CW=2 instance checks saturation.
module tb_ring_slot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] slot, req, done;
    logic [3:0] gnt, gnt2;
    logic       busy, busy2, timeout, timeout2, slot_err, slot_err2;
    logic [7:0] miss_cnt;
    logic [1:0] miss_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ring_slot_arbiter #(.N(4), .HOLD_MAX(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .slot(slot), .req(req), .done(done),
        .gnt(gnt), .busy(busy), .timeout(timeout),
        .miss_cnt(miss_cnt), .slot_err(slot_err)
    );

    ring_slot_arbiter #(.N(4), .HOLD_MAX(8), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .slot(slot), .req(req), .done(done),
        .gnt(gnt2), .busy(busy2), .timeout(timeout2),
        .miss_cnt(miss_cnt2), .slot_err(slot_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One posedge, then settle on the following negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; slot = 4'b0001; req = '0; done = '0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);
        chk("rst_miss", 32'(miss_cnt), 32'h0);
        chk("rst_err", 32'(slot_err), 32'h0);
        rst = 1'b0;
        tick();

        // grant then release via done
        slot = 4'b0001; req = 4'b0001;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h1);
        chk("t2_busy", 32'(busy), 32'h1);
        slot = 4'b0010; req = '0; done = 4'b0001;
        tick();
        chk("t2_rel_gnt", 32'(gnt), 32'h0);
        chk("t2_rel_busy", 32'(busy), 32'h0);
        chk("t2_rel_tmo", 32'(timeout), 32'h0);
        done = '0;

        // done on a non-granted bit is ignored; hold runs to timeout
        slot = 4'b0100; req = 4'b0100;
        tick();
        slot = 4'b0001; req = '0; done = 4'b1011;
        chk("t3_hold0", 32'(gnt), 32'h4);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("t3_hold%0d", i), 32'({gnt, timeout}), 32'h8);
        end
        tick();
        chk("t3_exp_gnt", 32'(gnt), 32'h0);
        chk("t3_exp_tmo", 32'(timeout), 32'h1);
        chk("t3_exp_busy", 32'(busy), 32'h0);
        done = '0;
        tick();
        chk("t3_tmo_pulse", 32'(timeout), 32'h0);

        // done and expiry on the same edge: no timeout
        slot = 4'b0100; req = 4'b0100;
        tick();
        slot = 4'b0001; req = '0;
        for (int i = 1; i < 8; i++) tick();
        chk("t3b_last", 32'(gnt), 32'h4);
        done = 4'b0100;
        tick();
        chk("t3b_gnt", 32'(gnt), 32'h0);
        chk("t3b_tmo", 32'(timeout), 32'h0);
        done = '0;
        chk("t3_miss", 32'(miss_cnt), 32'h0);

        // async reset mid-grant
        slot = 4'b0010; req = 4'b0010;
        tick();
        chk("t1_pre", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        chk("t1_gnt", 32'(gnt), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        slot = 4'b0001; req = '0;
        #1 rst = 1'b0;
        tick();
        chk("t1_idle", 32'(busy), 32'h0);

        // miss counting and saturation
        slot = 4'b0001; req = 4'b0001;
        tick();
        req = 4'b1110;
        slot = 4'b0010; tick();
        slot = 4'b0100; tick();
        slot = 4'b1000; tick();
        chk("t4_miss3", 32'(miss_cnt), 32'h3);
        chk("t4_sat_a", 32'(miss_cnt2), 32'h3);
        slot = 4'b0010; tick();
        slot = 4'b0100; tick();
        chk("t4_miss5", 32'(miss_cnt), 32'h5);
        chk("t4_sat_b", 32'(miss_cnt2), 32'h3);
        chk("t4_held", 32'(gnt), 32'h1);
        req = '0; done = 4'b0001;
        tick();
        chk("t4_rel", 32'(gnt2), 32'h0);
        done = '0;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // multi-bit slot
        slot = 4'b0011; req = 4'b0011;
        tick();
`ifdef RING_SLOT_CHECK_EN
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_err", 32'(slot_err), 32'h1);
`else
        chk("t5_gnt", 32'(gnt), 32'h1);
        chk("t5_err", 32'(slot_err), 32'h0);
`endif
        slot = 4'b0001; req = '0; done = 4'b0001;
        tick();
        done = '0; req = 4'b0001;
        tick();
        chk("t5_gnt2", 32'(gnt), 32'h1);
`ifdef RING_SLOT_CHECK_EN
        chk("t5_sticky", 32'(slot_err), 32'h1);
`else
        chk("t5_sticky", 32'(slot_err), 32'h0);
`endif
        req = '0; done = 4'b0001;
        tick();
        done = '0;

        // release then immediate request: one idle cycle first
        slot = 4'b0001; req = 4'b0001;
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        done = 4'b0001; slot = 4'b0010; req = 4'b0010;
        tick();
        chk("t6_idle_gnt", 32'(gnt), 32'h0);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        done = '0;
        tick();
        chk("t6_new_gnt", 32'(gnt), 32'h2);
        chk("t6_miss", 32'(miss_cnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
